// File: rtl/ddr_cmd_sched_if.sv
// Request/operation handshake bundle between the AXI-side address
// channels, the operation scheduler and the DDR command engine.
interface ddr_cmd_sched_if #(
    parameter int ADDR_W = 26
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic              op_valid;
    logic              op_ready;
    logic [1:0]        op_type;
    logic [ADDR_W-1:0] op_addr;
    logic [7:0]        op_len;
    logic              op_done;

    modport master (
        output awvalid, awaddr, awlen,
        output arvalid, araddr, arlen,
        output op_ready, op_done,
        input  awready, arready,
        input  op_valid, op_type, op_addr, op_len
    );

    modport slave (
        input  awvalid, awaddr, awlen,
        input  arvalid, araddr, arlen,
        input  op_ready, op_done,
        output awready, arready,
        output op_valid, op_type, op_addr, op_len
    );
endinterface

// File: rtl/ddr_cmd_sched.sv
// One-at-a-time write/read/refresh operation scheduler with refresh debt.
// Optional DDR_SCHED_STATS_EN adds saturating per-type accept counters.
module ddr_cmd_sched #(
    parameter int BA_BITS    = 2,
    parameter int ROW_BITS   = 13,
    parameter int COL_BITS   = 11,
    parameter int DQ_LEVEL   = 1,
    parameter int TREFI      = 780,
    parameter int REF_URGENT = 4
) (
    input  logic       core_clk,
    input  logic       core_rst,
    ddr_cmd_sched_if.slave bus,
    output logic [3:0] ref_debt
`ifdef DDR_SCHED_STATS_EN
    ,
    output logic [15:0] stat_wr,
    output logic [15:0] stat_rd,
    output logic [15:0] stat_ref
`endif
);
    localparam int AW = BA_BITS + ROW_BITS + COL_BITS + DQ_LEVEL - 1;
    localparam int TW = $clog2(TREFI);

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_WR   = 2'd1;
    localparam logic [1:0] OP_RD   = 2'd2;
    localparam logic [1:0] OP_REF  = 2'd3;

    localparam logic [3:0]    DEBT_MAX = 4'd8;
    localparam logic [3:0]    URGENT   = 4'(REF_URGENT);
    localparam logic [TW-1:0] RELOAD   = TW'(TREFI - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY
    } state_t;

    state_t        state;
    logic [TW-1:0] tmr;
    logic          tick;
    logic          op_acc;
    logic          ref_acc;
    logic          last_rd;
    logic          urgent;
    logic          rw_req;
    logic          pick_wr;
    logic          granting;
    logic          ref_want;

    assign tick     = (tmr == '0);
    assign op_acc   = bus.op_valid & bus.op_ready;
    assign ref_acc  = op_acc & (bus.op_type == OP_REF);
    assign urgent   = (ref_debt >= URGENT);
    assign rw_req   = bus.awvalid | bus.arvalid;
    assign pick_wr  = bus.awvalid & (~bus.arvalid | last_rd);
    assign granting = bus.awready | bus.arready;
    assign ref_want = urgent | (~rw_req & (ref_debt != 4'd0));

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            tmr <= RELOAD;
        end else if (tick) begin
            tmr <= RELOAD;
        end else begin
            tmr <= tmr - 1'b1;
        end
    end

    // A tick and a refresh accept in the same cycle cancel out.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            ref_debt <= 4'd0;
        end else if (tick && !ref_acc) begin
            if (ref_debt != DEBT_MAX) begin
                ref_debt <= ref_debt + 4'd1;
            end
        end else if (!tick && ref_acc) begin
            if (ref_debt != 4'd0) begin
                ref_debt <= ref_debt - 4'd1;
            end
        end
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state        <= IDLE;
            bus.awready  <= 1'b0;
            bus.arready  <= 1'b0;
            bus.op_valid <= 1'b0;
            bus.op_type  <= OP_NONE;
            bus.op_addr  <= {AW{1'b0}};
            bus.op_len   <= 8'd0;
            last_rd      <= 1'b1;
        end else begin
            bus.awready <= 1'b0;
            bus.arready <= 1'b0;
            unique case (state)
                IDLE: begin
                    // The ready pulse cycle is still IDLE; no new decision.
                    if (granting) begin
                        bus.op_valid <= 1'b1;
                        bus.op_type  <= bus.awready ? OP_WR : OP_RD;
                        state        <= ISSUE;
                    end else if (ref_want) begin
                        bus.op_valid <= 1'b1;
                        bus.op_type  <= OP_REF;
                        bus.op_addr  <= {AW{1'b0}};
                        bus.op_len   <= 8'd0;
                        state        <= ISSUE;
                    end else if (rw_req) begin
                        if (pick_wr) begin
                            bus.awready <= 1'b1;
                            bus.op_addr <= bus.awaddr;
                            bus.op_len  <= bus.awlen;
                            last_rd     <= 1'b0;
                        end else begin
                            bus.arready <= 1'b1;
                            bus.op_addr <= bus.araddr;
                            bus.op_len  <= bus.arlen;
                            last_rd     <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.op_ready) begin
                        bus.op_valid <= 1'b0;
                        bus.op_type  <= OP_NONE;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.op_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DDR_SCHED_STATS_EN
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            stat_wr  <= 16'd0;
            stat_rd  <= 16'd0;
            stat_ref <= 16'd0;
        end else if (op_acc) begin
            unique case (1'b1)
                (bus.op_type == OP_WR): begin
                    if (stat_wr != 16'hFFFF) begin
                        stat_wr <= stat_wr + 16'd1;
                    end
                end
                (bus.op_type == OP_RD): begin
                    if (stat_rd != 16'hFFFF) begin
                        stat_rd <= stat_rd + 16'd1;
                    end
                end
                (bus.op_type == OP_REF): begin
                    if (stat_ref != 16'hFFFF) begin
                        stat_ref <= stat_ref + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Bench for ddr_cmd_sched: arbitration vector table, refresh corner
// sequences and a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_ddr_cmd_sched;
    localparam int AW    = 26;
    localparam int TREFI = 16;
    localparam int URG   = 4;

    logic       core_clk = 1'b0;
    logic       core_rst = 1'b1;
    logic [3:0] ref_debt;
`ifdef DDR_SCHED_STATS_EN
    logic [15:0] stat_wr;
    logic [15:0] stat_rd;
    logic [15:0] stat_ref;
`endif

    int total = 0;
    int bad   = 0;
    int pe;

    ddr_cmd_sched_if #(.ADDR_W(AW)) bus ();

    ddr_cmd_sched #(
        .TREFI      (TREFI),
        .REF_URGENT (URG)
    ) dut (
        .core_clk (core_clk),
        .core_rst (core_rst),
        .bus      (bus),
        .ref_debt (ref_debt)
`ifdef DDR_SCHED_STATS_EN
        ,
        .stat_wr  (stat_wr),
        .stat_rd  (stat_rd),
        .stat_ref (stat_ref)
`endif
    );

    always #5 core_clk = ~core_clk;

    // Posedges since reset release; used to land on tick edges.
    always @(posedge core_clk or posedge core_rst) begin
        if (core_rst) pe <= 0;
        else pe <= pe + 1;
    end

    typedef struct {
        logic          aw;
        logic          ar;
        logic [AW-1:0] awa;
        logic [AW-1:0] ara;
        logic [7:0]    awl;
        logic [7:0]    arl;
        logic [1:0]    exp;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge core_clk);
    endtask

    task automatic idle_inputs();
        bus.awvalid  = 1'b0;
        bus.arvalid  = 1'b0;
        bus.awaddr   = '0;
        bus.araddr   = '0;
        bus.awlen    = 8'd0;
        bus.arlen    = 8'd0;
        bus.op_ready = 1'b0;
        bus.op_done  = 1'b0;
    endtask

    task automatic do_reset();
        core_rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        core_rst = 1'b0;
    endtask

    task automatic wait_op(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (bus.op_valid) ok = 1'b1;
            else cyc();
        end
        chk("op_seen", ok, 1);
    endtask

    task automatic wait_grant(output logic [1:0] g);
        g = 2'd0;
        for (int i = 0; i < 64 && g == 2'd0; i++) begin
            cyc();
            g = {bus.arready, bus.awready};
        end
        chk("grant_seen", (g != 2'd0), 1);
    endtask

    task automatic serve(input int hold, input int dly,
                         output logic [1:0] t,
                         output logic [AW-1:0] a,
                         output logic [7:0] l);
        logic ok;
        wait_op(ok);
        t = bus.op_type;
        a = bus.op_addr;
        l = bus.op_len;
        if (!ok) return;
        for (int i = 0; i < hold; i++) begin
            cyc();
            chk("hold_stable",
                {bus.op_valid, bus.op_type, bus.op_addr, bus.op_len},
                {1'b1, t, a, l});
            chk("hold_noready", {bus.awready, bus.arready}, 0);
        end
        bus.op_ready = 1'b1;
        cyc();
        bus.op_ready = 1'b0;
        chk("accept_clear", {bus.op_valid, bus.op_type}, 0);
        for (int i = 0; i < dly; i++) cyc();
        bus.op_done = 1'b1;
        cyc();
        bus.op_done = 1'b0;
    endtask

    task automatic drain();
        logic [1:0]    t;
        logic [AW-1:0] a;
        logic [7:0]    l;
        for (int i = 0; i < 8 && ref_debt != 4'd0; i++) begin
            serve(0, 0, t, a, l);
            chk("drain_ref", t, 3);
        end
    endtask

    task automatic run_vectors();
        logic [1:0]    g;
        logic [1:0]    t;
        logic [AW-1:0] a;
        logic [7:0]    l;
        for (int i = 0; i < 10; i++) begin
            drain();
            bus.awvalid = vt[i].aw;
            bus.arvalid = vt[i].ar;
            bus.awaddr  = vt[i].awa;
            bus.araddr  = vt[i].ara;
            bus.awlen   = vt[i].awl;
            bus.arlen   = vt[i].arl;
            wait_grant(g);
            bus.awvalid = 1'b0;
            bus.arvalid = 1'b0;
            chk("vec_grant", g, vt[i].exp);
            chk("vec_onehot", {bus.awready & bus.arready}, 0);
            serve(0, 1, t, a, l);
            chk("vec_type", t, vt[i].exp);
            chk("vec_addr", a, (vt[i].exp == 2'd1) ? vt[i].awa : vt[i].ara);
            chk("vec_len", l, (vt[i].exp == 2'd1) ? vt[i].awl : vt[i].arl);
        end
    endtask

    task automatic seq_first_refresh();
        do_reset();
        chk("rst_outs",
            {bus.awready, bus.arready, bus.op_valid, bus.op_type,
             bus.op_addr, bus.op_len, ref_debt}, 0);
        for (int i = 0; i < 15; i++) cyc();
        chk("debt_pre_tick", ref_debt, 0);
        cyc();
        chk("debt_tick16", ref_debt, 1);
        cyc();
        chk("ref_issue", {bus.op_valid, bus.op_type, bus.op_addr, bus.op_len},
            {1'b1, 2'd3, {AW{1'b0}}, 8'd0});
        bus.op_ready = 1'b1;
        cyc();
        bus.op_ready = 1'b0;
        chk("ref_acc_debt", ref_debt, 0);
        cyc();
        cyc();
        bus.op_done = 1'b1;
        cyc();
        bus.op_done = 1'b0;
        cyc();
        chk("ref_back_idle", {bus.op_valid, ref_debt}, 0);
    endtask

    task automatic seq_hold_issue();
        logic [1:0]    g;
        logic [1:0]    t;
        logic [AW-1:0] a;
        logic [7:0]    l;
        do_reset();
        bus.awvalid = 1'b1;
        bus.awaddr  = 26'h2A5_5A5A;
        bus.awlen   = 8'h7C;
        wait_grant(g);
        bus.awvalid = 1'b0;
        bus.arvalid = 1'b1;
        bus.araddr  = 26'h111_2222;
        chk("hold_grant", g, 1);
        serve(10, 2, t, a, l);
        chk("hold_type", t, 1);
        chk("hold_addr", {a, l}, {26'h2A5_5A5A, 8'h7C});
        bus.arvalid = 1'b0;
    endtask

    task automatic seq_urgent();
        logic [1:0]    g;
        logic          ok;
        logic [1:0]    t;
        logic [AW-1:0] a;
        logic [7:0]    l;
        do_reset();
        bus.awvalid = 1'b1;
        bus.arvalid = 1'b1;
        bus.awaddr  = 26'h000_0ABC;
        bus.araddr  = 26'h3FF_0F0F;
        bus.awlen   = 8'h11;
        bus.arlen   = 8'h22;
        wait_grant(g);
        chk("urg_first_w", g, 1);
        wait_op(ok);
        bus.op_ready = 1'b1;
        cyc();
        bus.op_ready = 1'b0;
        for (int i = 0; i < 100 && ref_debt != 4'd5; i++) begin
            cyc();
            chk("urg_noready", {bus.awready, bus.arready}, 0);
        end
        chk("urg_debt5", ref_debt, 5);
        bus.op_done = 1'b1;
        cyc();
        bus.op_done = 1'b0;
        serve(0, 0, t, a, l);
        chk("urg_ref1", t, 3);
        serve(0, 0, t, a, l);
        chk("urg_ref2", t, 3);
        chk("urg_debt3", ref_debt, 3);
        serve(0, 0, t, a, l);
        chk("urg_rd", {t, a, l}, {2'd2, 26'h3FF_0F0F, 8'h22});
        serve(0, 0, t, a, l);
        chk("urg_wr", {t, a, l}, {2'd1, 26'h000_0ABC, 8'h11});
        bus.awvalid = 1'b0;
        bus.arvalid = 1'b0;
        serve(0, 0, t, a, l);
        chk("urg_low_ref", t, 3);
    endtask

    task automatic seq_tick_sat_reset();
        logic          ok;
        logic [1:0]    g;
        logic [1:0]    t;
        logic [AW-1:0] a;
        logic [7:0]    l;
        do_reset();
        wait_op(ok);
        chk("coin_type", bus.op_type, 3);
        for (int i = 0; i < 40 && pe != 31; i++) cyc();
        chk("coin_debt_pre", ref_debt, 1);
        bus.op_ready = 1'b1;
        cyc();
        bus.op_ready = 1'b0;
        chk("coin_debt", ref_debt, 1);
        bus.op_done = 1'b1;
        cyc();
        bus.op_done = 1'b0;
        wait_op(ok);
        for (int i = 0; i < 10 * TREFI; i++) cyc();
        chk("sat_debt8", ref_debt, 8);
        bus.op_ready = 1'b1;
        cyc();
        bus.op_ready = 1'b0;
        chk("sat_in_busy", bus.op_valid, 0);
        core_rst = 1'b1;
        #1;
        chk("rst_busy_outs",
            {bus.awready, bus.arready, bus.op_valid, bus.op_type,
             bus.op_addr, bus.op_len, ref_debt}, 0);
`ifdef DDR_SCHED_STATS_EN
        chk("rst_stats", {stat_wr, stat_rd, stat_ref}, 0);
`endif
        cyc();
        core_rst = 1'b0;
        bus.awvalid = 1'b1;
        bus.awaddr  = 26'h155_1234;
        bus.awlen   = 8'h05;
        wait_grant(g);
        bus.awvalid = 1'b0;
        chk("post_rst_grant", g, 1);
        serve(0, 0, t, a, l);
        chk("post_rst_op", {t, a, l}, {2'd1, 26'h155_1234, 8'h05});
    endtask

    task automatic run_random(input int n);
        int            ph;
        int            mpe;
        logic [1:0]    mt;
        logic [AW-1:0] ma;
        logic [7:0]    ml;
        int            md;
        logic          mlast_rd;
        logic          tk;
        logic          racc;
        int            nwr;
        int            nrd;
        int            nref;
        do_reset();
        ph = 0;
        mpe = 0;
        mt = 2'd0;
        ma = '0;
        ml = 8'd0;
        md = 0;
        mlast_rd = 1'b1;
        nwr = 0;
        nrd = 0;
        nref = 0;
        for (int i = 0; i < n; i++) begin
            chk("rnd_debt", ref_debt, md);
            chk("rnd_ready", {bus.arready, bus.awready},
                (ph == 1) ? mt : 2'd0);
            chk("rnd_op", {bus.op_valid, bus.op_type},
                (ph == 2) ? {1'b1, mt} : 3'd0);
            if (ph == 2) chk("rnd_addr", {bus.op_addr, bus.op_len}, {ma, ml});
            bus.awvalid  = ($urandom_range(0, 9) < 4);
            bus.arvalid  = ($urandom_range(0, 9) < 4);
            bus.awaddr   = AW'($urandom);
            bus.araddr   = AW'($urandom);
            bus.awlen    = 8'($urandom);
            bus.arlen    = 8'($urandom);
            bus.op_ready = ($urandom_range(0, 9) < 4);
            bus.op_done  = ($urandom_range(0, 9) < 3);
            tk = ((mpe + 1) % TREFI == 0);
            mpe++;
            racc = (ph == 2) && bus.op_ready && (mt == 2'd3);
            case (ph)
                0: begin
                    if (md >= URG || (!bus.awvalid && !bus.arvalid && md > 0)) begin
                        ph = 2;
                        mt = 2'd3;
                        ma = '0;
                        ml = 8'd0;
                    end else if (bus.awvalid || bus.arvalid) begin
                        ph = 1;
                        if (bus.awvalid && (!bus.arvalid || mlast_rd)) begin
                            mt = 2'd1;
                            ma = bus.awaddr;
                            ml = bus.awlen;
                            mlast_rd = 1'b0;
                        end else begin
                            mt = 2'd2;
                            ma = bus.araddr;
                            ml = bus.arlen;
                            mlast_rd = 1'b1;
                        end
                    end
                end
                1: ph = 2;
                2: begin
                    if (bus.op_ready) begin
                        ph = 3;
                        if (mt == 2'd1) nwr++;
                        else if (mt == 2'd2) nrd++;
                        else nref++;
                    end
                end
                default: if (bus.op_done) ph = 0;
            endcase
            if (tk && !racc) md = (md < 8) ? md + 1 : 8;
            else if (!tk && racc) md = md - 1;
            cyc();
        end
        chk("rnd_nonzero", (nwr > 0 && nrd > 0 && nref > 0), 1);
`ifdef DDR_SCHED_STATS_EN
        chk("rnd_stats", {stat_wr, stat_rd, stat_ref},
            {16'(nwr), 16'(nrd), 16'(nref)});
`endif
        idle_inputs();
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b1, 26'h012_3456, 26'h3AB_CDEF, 8'h0F, 8'h03, 2'd1};
        vt[1] = '{1'b1, 1'b1, 26'h000_0001, 26'h200_0000, 8'h00, 8'hFF, 2'd2};
        vt[2] = '{1'b1, 1'b1, 26'h3FF_FFFF, 26'h155_5555, 8'h80, 8'h01, 2'd1};
        vt[3] = '{1'b1, 1'b1, 26'h0F0_F0F0, 26'h2AA_AAAA, 8'h40, 8'h7F, 2'd2};
        vt[4] = '{1'b1, 1'b0, 26'h123_4567, 26'h000_0000, 8'h10, 8'h00, 2'd1};
        vt[5] = '{1'b1, 1'b0, 26'h234_5678, 26'h111_1111, 8'h20, 8'h21, 2'd1};
        vt[6] = '{1'b1, 1'b1, 26'h345_6789, 26'h098_7654, 8'h30, 8'h31, 2'd2};
        vt[7] = '{1'b0, 1'b1, 26'h111_0000, 26'h0AB_CDEF, 8'h55, 8'hAA, 2'd2};
        vt[8] = '{1'b1, 1'b1, 26'h0C0_FFEE, 26'h0BE_EF00, 8'hC3, 8'h3C, 2'd1};
        vt[9] = '{1'b0, 1'b1, 26'h000_0000, 26'h1DE_ADBE, 8'h00, 8'hE1, 2'd2};
        idle_inputs();
        do_reset();
        run_vectors();
`ifdef DDR_SCHED_STATS_EN
        chk("vec_stat_wr", stat_wr, 5);
        chk("vec_stat_rd", stat_rd, 5);
`endif
        seq_first_refresh();
        seq_hold_issue();
        seq_urgent();
        seq_tick_sat_reset();
        run_random(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
